// File: rtl/adder6_sum_accum.sv
// Block accumulator behind the 6-bit adder: sums N_SAMPLES 7-bit results into a
// saturating ACC_W-bit total and hands each block off over a valid/ready output.
module adder6_sum_accum #(
  parameter int unsigned N_SAMPLES = 8,
  parameter int unsigned ACC_W     = 10,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       sum_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] out_total,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sat, sat_nxt;
  logic [ACC_W-1:0] out_total_nxt;
  logic [CNT_W-1:0] out_count_nxt;
  logic             out_sat_nxt;
  logic             out_valid_nxt;

  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic             add_sat;
  logic [ACC_W-1:0] sum_clip;
  logic             close;

  assign in_ready = (state == ACCUM);
  assign accept   = in_valid & in_ready;

  // One extra bit of headroom exposes overflow so the add can clip to all ones.
  assign sum_wide = {1'b0, acc} + (ACC_W + 1)'(sum_in);
  assign add_sat  = sum_wide[ACC_W];
  assign sum_clip = add_sat ? '1 : sum_wide[ACC_W-1:0];

  assign close = (state == ACCUM) &&
                 ((accept && (cnt == CNT_W'(N_SAMPLES - 1))) ||
                  (flush && (accept || (cnt != '0))));

  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    sat_nxt       = sat;
    out_total_nxt = out_total;
    out_count_nxt = out_count;
    out_sat_nxt   = out_sat;
    out_valid_nxt = out_valid;

    unique case (state)
      ACCUM: begin
        if (close) begin
          out_total_nxt = accept ? sum_clip : acc;
          out_count_nxt = cnt + CNT_W'(accept);
          out_sat_nxt   = sat | (accept & add_sat);
          out_valid_nxt = 1'b1;
          acc_nxt       = '0;
          cnt_nxt       = '0;
          sat_nxt       = 1'b0;
          state_nxt     = HOLD;
        end else if (accept) begin
          acc_nxt = sum_clip;
          cnt_nxt = cnt + 1'b1;
          sat_nxt = sat | add_sat;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_nxt = 1'b0;
          state_nxt     = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      cnt       <= '0;
      sat       <= 1'b0;
      out_total <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      sat       <= sat_nxt;
      out_total <= out_total_nxt;
      out_count <= out_count_nxt;
      out_sat   <= out_sat_nxt;
      out_valid <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_adder6_sum_accum.sv
// Bench for adder6_sum_accum: a default instance and a narrow (ACC_W=8, N=3) instance
// share one stimulus stream; each is tracked by a block-sum reference model.
module tb_adder6_sum_accum;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] sum_in = '0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;

  logic       in_ready0, out_sat0, out_valid0;
  logic [9:0] out_total0;
  logic [3:0] out_count0;
  logic       in_ready1, out_sat1, out_valid1;
  logic [7:0] out_total1;
  logic [3:0] out_count1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  adder6_sum_accum #(.N_SAMPLES(8), .ACC_W(10), .CNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .sum_in(sum_in), .in_valid(in_valid), .in_ready(in_ready0),
    .flush(flush), .out_total(out_total0), .out_count(out_count0), .out_sat(out_sat0),
    .out_valid(out_valid0), .out_ready(out_ready)
  );

  adder6_sum_accum #(.N_SAMPLES(3), .ACC_W(8), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .sum_in(sum_in), .in_valid(in_valid), .in_ready(in_ready1),
    .flush(flush), .out_total(out_total1), .out_count(out_count1), .out_sat(out_sat1),
    .out_valid(out_valid1), .out_ready(out_ready)
  );

  // Reference: true (unclipped) block sum and sample count; clipping applied at close.
  int unsigned m_n[2]   = '{8, 3};
  int unsigned m_max[2] = '{1023, 255};
  int unsigned m_sum[2], m_num[2], m_tot[2], m_cnt[2];
  bit          m_hold[2], m_sat[2], m_ov[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k, input bit v, input int unsigned d,
                            input bit fl, input bit ordy, input bit r);
    int unsigned nsum, nnum;
    bit acc_ok;
    if (r) begin
      m_hold[k] = 0; m_sum[k] = 0; m_num[k] = 0;
      m_tot[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_ov[k] = 0;
    end else if (m_hold[k]) begin
      if (ordy) begin
        m_hold[k] = 0;
        m_ov[k] = 0;
      end
    end else begin
      acc_ok = v;
      nsum = m_sum[k] + (acc_ok ? d : 0);
      nnum = m_num[k] + (acc_ok ? 1 : 0);
      if ((acc_ok && nnum == m_n[k]) || (fl && nnum != 0)) begin
        m_tot[k] = (nsum > m_max[k]) ? m_max[k] : nsum;
        m_cnt[k] = nnum;
        m_sat[k] = (nsum > m_max[k]);
        m_ov[k] = 1; m_hold[k] = 1;
        m_sum[k] = 0; m_num[k] = 0;
      end else begin
        m_sum[k] = nsum;
        m_num[k] = nnum;
      end
    end
  endtask

  task automatic step(input bit v, input int unsigned d, input bit fl, input bit ordy, input bit r);
    in_valid = v; sum_in = 7'(d); flush = fl; out_ready = ordy; rst = r;
    model_edge(0, v, d, fl, ordy, r);
    model_edge(1, v, d, fl, ordy, r);
    @(posedge clk);
    #1;
    chk("d0.in_ready",  32'(in_ready0),  32'(!m_hold[0]));
    chk("d0.out_valid", 32'(out_valid0), 32'(m_ov[0]));
    chk("d0.out_total", 32'(out_total0), m_tot[0]);
    chk("d0.out_count", 32'(out_count0), m_cnt[0]);
    chk("d0.out_sat",   32'(out_sat0),   32'(m_sat[0]));
    chk("d1.in_ready",  32'(in_ready1),  32'(!m_hold[1]));
    chk("d1.out_valid", 32'(out_valid1), 32'(m_ov[1]));
    chk("d1.out_total", 32'(out_total1), m_tot[1]);
    chk("d1.out_count", 32'(out_count1), m_cnt[1]);
    chk("d1.out_sat",   32'(out_sat1),   32'(m_sat[1]));
  endtask

  initial begin
    // Full block of 126s
    step(0, 0, 0, 1, 1);
    chk("rst.in_ready", 32'(in_ready0), 32'd1);
    chk("rst.out_valid", 32'(out_valid0), 32'd0);
    for (int i = 0; i < 8; i++) step(1, 126, 0, 1, 0);
    chk("full.valid", 32'(out_valid0), 32'd1);
    chk("full.total", 32'(out_total0), 32'd1008);
    chk("full.count", 32'(out_count0), 32'd8);
    chk("full.sat", 32'(out_sat0), 32'd0);
    step(0, 0, 0, 1, 0);
    chk("full.release_valid", 32'(out_valid0), 32'd0);
    chk("full.release_ready", 32'(in_ready0), 32'd1);

    // Gapped inputs then flush alone; then flush with empty block
    step(0, 0, 0, 1, 1);
    step(1, 3, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 5, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 7, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("flush.valid", 32'(out_valid0), 32'd1);
    chk("flush.total", 32'(out_total0), 32'd15);
    chk("flush.count", 32'(out_count0), 32'd3);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    chk("flush_empty.valid", 32'(out_valid0), 32'd0);
    step(0, 0, 0, 1, 0);
    chk("flush_empty.valid2", 32'(out_valid0), 32'd0);

    // Flush together with an accept
    step(0, 0, 0, 1, 1);
    step(1, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0);
    step(1, 10, 1, 0, 0);
    chk("flush_acc.total", 32'(out_total0), 32'd13);
    chk("flush_acc.count", 32'(out_count0), 32'd3);

    // Back-pressure while holding
    for (int i = 0; i < 5; i++) begin
      step(1, 9, 0, 0, 0);
      chk("hold.in_ready", 32'(in_ready0), 32'd0);
      chk("hold.total", 32'(out_total0), 32'd13);
    end
    step(1, 9, 0, 1, 0);
    chk("hold.resume", 32'(in_ready0), 32'd1);
    step(1, 9, 0, 1, 0);

    // Saturation in the narrow instance, then a clean block
    step(0, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(1, 100, 0, 1, 0);
    chk("sat.total", 32'(out_total1), 32'd255);
    chk("sat.count", 32'(out_count1), 32'd3);
    chk("sat.sat", 32'(out_sat1), 32'd1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 1, 0);
    chk("unsat.total", 32'(out_total1), 32'd3);
    chk("unsat.sat", 32'(out_sat1), 32'd0);

    // Reset mid-block, then reset while holding
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0);
    chk("abort.total", 32'(out_total0), 32'd8);
    chk("abort.count", 32'(out_count0), 32'd8);
    chk("abort.valid", 32'(out_valid0), 32'd1);
    step(0, 0, 0, 0, 1);
    chk("rst_hold.valid", 32'(out_valid0), 32'd0);

    // Randomized traffic including 127 and occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 127), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder6_sum_accum.md
Name: adder6_sum_accum

Overview:
- Downstream stage of the 6-bit adder. Consumes its 7-bit sum results (0..126) as a valid/ready stream.
- Accumulates a fixed number of samples into a wider running total.
- Presents each completed (or flushed) total plus its sample count on a valid/ready output.
- Output holds until accepted; input is back-pressured while the output is pending.

Parameters:
- N_SAMPLES, 8, number of sums per block; legal range 1..(2**CNT_W - 1).
- ACC_W, 10, accumulator/total width; need not cover N_SAMPLES*126, saturation applies.
- CNT_W, 4, width of the sample counter and the out_count port.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- sum_in  input  7  sum from the adder, treated as unsigned 0..127.
- in_valid  input  1  sum_in is valid this cycle.
- in_ready  output  1  block accepts sum_in this cycle.
- flush  input  1  close the current block early (sampled in ACCUM only).
- out_total  output  ACC_W  accumulated total of the block.
- out_count  output  CNT_W  number of samples in out_total.
- out_sat  output  1  total saturated during this block.
- out_valid  output  1  out_total/out_count/out_sat valid.
- out_ready  input  1  downstream accepts output this cycle.

Behaviour:
- Reset values (rst high at a rising edge):
  - state=ACCUM, acc=0, cnt=0, sat=0.
  - out_valid=0, out_total=0, out_count=0, out_sat=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-block or mid-HOLD discards all partial and pending data; no output is produced for it.
- States: ACCUM, HOLD. in_ready = (state==ACCUM), combinational from state only.
- Accept: in_valid & in_ready.
- ACCUM, accept without close:
  - nxt = acc + sum_in, computed at ACC_W+1 bits.
  - If nxt > 2**ACC_W-1: acc <= all ones and sat <= 1; otherwise acc <= nxt.
  - cnt <= cnt+1.
- Close condition in ACCUM: (accept & cnt==N_SAMPLES-1) OR (flush & (accept | cnt!=0)).
- On close:
  - out_total <= saturated nxt if accept, else acc.
  - out_count <= cnt+accept.
  - out_sat <= sat | (this add saturated).
  - acc <= 0, cnt <= 0, sat <= 0.
  - out_valid <= 1, state <= HOLD.
- flush with cnt==0 and no accept: ignored; no zero-count output is ever produced.
- flush together with an accept: the accepted sample is included in the block before it closes.
- flush in HOLD: ignored, not remembered.
- HOLD:
  - out_* stable, in_ready=0.
  - On out_ready: out_valid <= 0, state <= ACCUM.
  - New input is accepted starting the next cycle. Minimum block period is N_SAMPLES+1 cycles.
- Latency: out_valid asserts the cycle after the closing accept/flush edge.
- out_ready while out_valid=0 has no effect.
- sum_in is not range-checked; 127 is accumulated like any other value.
- With the defaults, 8*127 = 1016 < 1024, so saturation cannot occur.

Test Plan:
- Reset, then 8 back-to-back accepts of 0x7E (126) with out_ready=1 -> one cycle after the 8th accept: out_valid=1, out_total=1008, out_count=8, out_sat=0. Next cycle: out_valid=0, in_ready=1.
- Send 3, 5, 7 with a 1-cycle in_valid gap between each, then pulse flush alone -> out_total=15, out_count=3. Separately, flush with cnt==0 -> no out_valid.
- flush in the same cycle as accepting sum_in=10, with cnt=2 after prior inputs 1, 2 -> out_total=13, out_count=3.
- Complete a block, hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 throughout, out_* unchanged. When out_ready=1, ACCUM resumes and the next sample is accepted the following cycle.
- ACC_W=8, 3 samples of 100 with N_SAMPLES=3 -> out_total=255, out_count=3, out_sat=1. The next block of 1, 1, 1 gives out_total=3, out_sat=0.
- Assert rst after 4 accepted samples, then send 8 samples of 1 -> a single output with out_total=8, out_count=8; nothing from the aborted block. Assert rst during HOLD -> out_valid=0 the next cycle.
